softreg_ctrl: RTL

Software-register front end and run controller inside `PageRank`, directly downstream of the host/testbench SoftReg request driver. It decodes SoftReg writes into the graph parameter bank (vertex count, in-edge count, base addresses, round count) and sequences the PageRank rounds on a `DONE_READ_PARAMS` write. It issues one start pulse per round and swaps the ping-pong rank buffers between rounds. SoftReg reads return immediately, except a `DONE_ALL` read, which is held until all rounds complete.

---
 rtl/softreg_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/softreg_ctrl.sv
// softreg_ctrl: SoftReg front end and PageRank round sequencer.
//
// Decodes SoftReg writes into the graph parameter bank and, on a DONE_READ_PARAMS
// write, runs N_ROUNDS rounds: one round_start pulse per round, waiting for the
// engine's round_done between rounds. Rank buffers ping-pong on round_idx parity.
// Reads answer one cycle after the request, except DONE_ALL, which is held as a
// single pending read until the run reaches DONE.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   softreg_req_*                 request strobe, direction, address, write data
//   softreg_resp_valid/_data      registered read response
//   n_vert, n_inedges, vaddr,
//   ieaddr                        latched graph parameters
//   rank_rd_addr, rank_wr_addr    ping-pong rank buffer bases for this round
//   round_idx                     rounds completed in the current run
//   round_start / round_done      round launch pulse / engine completion pulse
//   running, done_all             run in progress / run finished
//
// The address map mirrors constants.v.
module softreg_ctrl #(
  parameter int unsigned ROUND_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               softreg_req_valid,
  input  logic               softreg_req_isWrite,
  input  logic [31:0]        softreg_req_addr,
  input  logic [63:0]        softreg_req_data,
  output logic               softreg_resp_valid,
  output logic [63:0]        softreg_resp_data,
  output logic [63:0]        n_vert,
  output logic [63:0]        n_inedges,
  output logic [63:0]        vaddr,
  output logic [63:0]        ieaddr,
  output logic [63:0]        rank_rd_addr,
  output logic [63:0]        rank_wr_addr,
  output logic [ROUND_W-1:0] round_idx,
  output logic               round_start,
  input  logic               round_done,
  output logic               running,
  output logic               done_all
);

  localparam logic [31:0] AddrNVert      = 32'h00;
  localparam logic [31:0] AddrNInedges   = 32'h08;
  localparam logic [31:0] AddrVaddr      = 32'h10;
  localparam logic [31:0] AddrIeaddr     = 32'h18;
  localparam logic [31:0] AddrWriteAddr0 = 32'h20;
  localparam logic [31:0] AddrWriteAddr1 = 32'h28;
  localparam logic [31:0] AddrNRounds    = 32'h30;
  localparam logic [31:0] AddrDoneParams = 32'h38;
  localparam logic [31:0] AddrDoneAll    = 32'h40;

  typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

  state_e               state_q, state_d;
  logic [63:0]          n_vert_q, n_vert_d;
  logic [63:0]          n_inedges_q, n_inedges_d;
  logic [63:0]          vaddr_q, vaddr_d;
  logic [63:0]          ieaddr_q, ieaddr_d;
  logic [63:0]          waddr0_q, waddr0_d;
  logic [63:0]          waddr1_q, waddr1_d;
  logic [ROUND_W-1:0]   n_rounds_q, n_rounds_d;
  logic [ROUND_W-1:0]   round_idx_q, round_idx_d;
  logic                 pending_q, pending_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [63:0]          resp_data_q, resp_data_d;
  logic                 round_start_q, round_start_d;
  logic                 running_q, running_d;
  logic                 done_all_q, done_all_d;

  logic                 wr_req, rd_req, cfg_open;
  logic [ROUND_W-1:0]   round_inc;
  logic [63:0]          rd_mux;

  assign wr_req    = softreg_req_valid && softreg_req_isWrite;
  assign rd_req    = softreg_req_valid && !softreg_req_isWrite;
  assign cfg_open  = (state_q == StIdle) || (state_q == StDone);
  assign round_inc = round_idx_q + ROUND_W'(1);

  always_comb begin
    rd_mux = '0;
    case (softreg_req_addr)
      AddrNVert:      rd_mux = n_vert_q;
      AddrNInedges:   rd_mux = n_inedges_q;
      AddrVaddr:      rd_mux = vaddr_q;
      AddrIeaddr:     rd_mux = ieaddr_q;
      AddrWriteAddr0: rd_mux = waddr0_q;
      AddrWriteAddr1: rd_mux = waddr1_q;
      AddrNRounds:    rd_mux = 64'(n_rounds_q);
      default:        rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    n_vert_d     = n_vert_q;
    n_inedges_d  = n_inedges_q;
    vaddr_d      = vaddr_q;
    ieaddr_d     = ieaddr_q;
    waddr0_d     = waddr0_q;
    waddr1_d     = waddr1_q;
    n_rounds_d   = n_rounds_q;
    round_idx_d  = round_idx_q;
    pending_d    = pending_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;

    // Parameter bank and run launch; writes during a run are dropped.
    if (wr_req && cfg_open) begin
      case (softreg_req_addr)
        AddrNVert:      n_vert_d    = softreg_req_data;
        AddrNInedges:   n_inedges_d = softreg_req_data;
        AddrVaddr:      vaddr_d     = softreg_req_data;
        AddrIeaddr:     ieaddr_d    = softreg_req_data;
        AddrWriteAddr0: waddr0_d    = softreg_req_data;
        AddrWriteAddr1: waddr1_d    = softreg_req_data;
        AddrNRounds:    n_rounds_d  = softreg_req_data[ROUND_W-1:0];
        AddrDoneParams: begin
          round_idx_d = '0;
          state_d     = (n_rounds_q == '0) ? StDone : StStart;
        end
        default: ;
      endcase
    end

    case (state_q)
      StStart: state_d = StWait;
      StWait: begin
        if (round_done) begin
          round_idx_d = round_inc;
          state_d     = (round_inc == n_rounds_q) ? StDone : StStart;
        end
      end
      default: ;
    endcase

    // A pending DONE_ALL read blocks all other reads until it is answered.
    if (pending_q) begin
      if (state_q == StDone) begin
        resp_valid_d = 1'b1;
        resp_data_d  = 64'(round_idx_q);
        pending_d    = 1'b0;
      end
    end else if (rd_req) begin
      if (softreg_req_addr == AddrDoneAll) begin
        if (state_q == StDone) begin
          resp_valid_d = 1'b1;
          resp_data_d  = 64'(round_idx_q);
        end else begin
          pending_d = 1'b1;
        end
      end else begin
        resp_valid_d = 1'b1;
        resp_data_d  = rd_mux;
      end
    end

    round_start_d = (state_d == StStart);
    running_d     = (state_d == StStart) || (state_d == StWait);
    done_all_d    = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      n_vert_q      <= '0;
      n_inedges_q   <= '0;
      vaddr_q       <= '0;
      ieaddr_q      <= '0;
      waddr0_q      <= '0;
      waddr1_q      <= '0;
      n_rounds_q    <= '0;
      round_idx_q   <= '0;
      pending_q     <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      round_start_q <= 1'b0;
      running_q     <= 1'b0;
      done_all_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_vert_q      <= n_vert_d;
      n_inedges_q   <= n_inedges_d;
      vaddr_q       <= vaddr_d;
      ieaddr_q      <= ieaddr_d;
      waddr0_q      <= waddr0_d;
      waddr1_q      <= waddr1_d;
      n_rounds_q    <= n_rounds_d;
      round_idx_q   <= round_idx_d;
      pending_q     <= pending_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      round_start_q <= round_start_d;
      running_q     <= running_d;
      done_all_q    <= done_all_d;
    end
  end

  assign softreg_resp_valid = resp_valid_q;
  assign softreg_resp_data  = resp_data_q;
  assign n_vert             = n_vert_q;
  assign n_inedges          = n_inedges_q;
  assign vaddr              = vaddr_q;
  assign ieaddr             = ieaddr_q;
  assign rank_rd_addr       = round_idx_q[0] ? waddr1_q : waddr0_q;
  assign rank_wr_addr       = round_idx_q[0] ? waddr0_q : waddr1_q;
  assign round_idx          = round_idx_q;
  assign round_start        = round_start_q;
  assign running            = running_q;
  assign done_all           = done_all_q;

endmodule
